// File: rtl/mode_select_fsm.sv
// rtl/mode_select_fsm.sv - game mode menu FSM with synchronized, debounced buttons and quit hold
// Buttons are synchronized, debounced and edge-detected; the FSM drives registered Moore outputs.
module mode_select_fsm #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int QUIT_HOLD_CYCLES = 100000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       select_mode_screen,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       btn_quit,
    input  logic       tutorial_done,
    input  logic       play_again,
    output logic [1:0] cursor,
    output logic       selected_a_mode,
    output logic       two_player_mode,
    output logic       tutorial_mode,
    output logic       end_game_early,
    output logic       end_tutorial
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int QW = $clog2(QUIT_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, MENU, ONE_PLAYER, TWO_PLAYER, TUTORIAL, DONE
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, deb;
    logic [2:0]    deb_q;
    logic [DW-1:0] deb_cnt [4];
    logic          press_up, press_down, press_enter, quit_level;
    state_t        state;
    logic [QW-1:0] quit_cnt;

    assign raw = {btn_quit, btn_enter, btn_down, btn_up};

    // Bit order in all button vectors: 0 up, 1 down, 2 enter, 3 quit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb[2:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_up    = deb[0] & ~deb_q[0];
    assign press_down  = deb[1] & ~deb_q[1];
    assign press_enter = deb[2] & ~deb_q[2];
    assign quit_level  = deb[3];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cursor          <= 2'd0;
            quit_cnt        <= '0;
            selected_a_mode <= 1'b0;
            two_player_mode <= 1'b0;
            tutorial_mode   <= 1'b0;
            end_game_early  <= 1'b0;
            end_tutorial    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (select_mode_screen) begin
                        state  <= MENU;
                        cursor <= 2'd0;
                    end
                end
                MENU: begin
                    quit_cnt <= '0;
                    if (!select_mode_screen) begin
                        state  <= IDLE;
                        cursor <= 2'd0;
                    end else if (press_enter) begin
                        case (cursor)
                            2'd0: begin
                                state           <= ONE_PLAYER;
                                selected_a_mode <= 1'b1;
                            end
                            2'd1: begin
                                state           <= TWO_PLAYER;
                                two_player_mode <= 1'b1;
                            end
                            default: begin
                                state           <= TUTORIAL;
                                selected_a_mode <= 1'b1;
                                tutorial_mode   <= 1'b1;
                            end
                        endcase
                    end else if (press_up) begin
                        cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
                    end else if (press_down) begin
                        cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
                    end
                end
                ONE_PLAYER, TWO_PLAYER: begin
                    // The counter saturates at the hold length; reaching it ends the game.
                    if (!quit_level) begin
                        quit_cnt <= '0;
                    end else if (quit_cnt == QW'(QUIT_HOLD_CYCLES - 1)) begin
                        quit_cnt       <= QW'(QUIT_HOLD_CYCLES);
                        state          <= DONE;
                        end_game_early <= 1'b1;
                    end else if (quit_cnt != QW'(QUIT_HOLD_CYCLES)) begin
                        quit_cnt <= quit_cnt + 1'b1;
                    end
                end
                TUTORIAL: begin
                    if (tutorial_done) begin
                        state         <= DONE;
                        tutorial_mode <= 1'b0;
                        end_tutorial  <= 1'b1;
                    end
                end
                DONE: begin
                    if (play_again) begin
                        state           <= IDLE;
                        cursor          <= 2'd0;
                        quit_cnt        <= '0;
                        selected_a_mode <= 1'b0;
                        two_player_mode <= 1'b0;
                        tutorial_mode   <= 1'b0;
                        end_game_early  <= 1'b0;
                        end_tutorial    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_select_fsm.sv
// tb/tb_mode_select_fsm.sv - self-checking bench for mode_select_fsm
// Directed scenario tasks plus a randomized operation sequence checked against an abstract model.
module tb_mode_select_fsm;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       select_mode_screen = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, btn_quit = 1'b0;
    logic       tutorial_done = 1'b0, play_again = 1'b0;
    logic [1:0] cursor;
    logic       selected_a_mode, two_player_mode, tutorial_mode, end_game_early, end_tutorial;
    logic [6:0] obs;

    int checks = 0;
    int failures = 0;

    mode_select_fsm #(.DEBOUNCE_CYCLES(4), .QUIT_HOLD_CYCLES(10)) dut (
        .clock(clock), .reset_n(reset_n), .select_mode_screen(select_mode_screen),
        .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_quit(btn_quit),
        .tutorial_done(tutorial_done), .play_again(play_again), .cursor(cursor),
        .selected_a_mode(selected_a_mode), .two_player_mode(two_player_mode),
        .tutorial_mode(tutorial_mode), .end_game_early(end_game_early), .end_tutorial(end_tutorial)
    );

    assign obs = {cursor, selected_a_mode, two_player_mode, tutorial_mode, end_game_early, end_tutorial};

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_enter = v;
            default: btn_quit = v;
        endcase
    endtask

    // A clean press: long enough to debounce high, then long enough to debounce low.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(6);
        set_btn(b, 1'b0);
        tick(6);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        select_mode_screen = 1'b0;
        btn_up = 0; btn_down = 0; btn_enter = 0; btn_quit = 0;
        tutorial_done = 0; play_again = 0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        select_mode_screen = 1'b1;
        btn_down = 1'b1;
        tick(3);
        checks++;
        if (obs !== 7'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 7'd0); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs !== 7'd0) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, 7'd0); end
        btn_down = 1'b0;
        tick(12);
        checks++;
        if (cursor !== 2'd0) begin failures++; $display("FAIL reset_no_early_press got=%0d exp=0", cursor); end
        do_reset();
    endtask

    task automatic test_bounce;
        int changes;
        logic [1:0] prev;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        for (int c = 0; c < 20; c++) begin
            btn_down = ((c / 2) % 2 == 0);
            tick(1);
            checks++;
            if (cursor !== 2'd0) begin failures++; $display("FAIL bounce_cursor cycle=%0d got=%0d exp=0", c, cursor); end
        end
        changes = 0;
        prev = cursor;
        btn_down = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c == 10) btn_down = 1'b0;
            tick(1);
            if (cursor !== prev) changes++;
            prev = cursor;
        end
        checks++;
        if (changes !== 1) begin failures++; $display("FAIL bounce_step_count got=%0d exp=1", changes); end
        checks++;
        if (cursor !== 2'd1) begin failures++; $display("FAIL bounce_final_cursor got=%0d exp=1", cursor); end
    endtask

    task automatic test_wrap_commit;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        press(0);
        checks++;
        if (cursor !== 2'd2) begin failures++; $display("FAIL wrap_up got=%0d exp=2", cursor); end
        btn_enter = 1'b1;
        tick(6);
        checks++;
        if (tutorial_mode !== 1'b0) begin failures++; $display("FAIL commit_early got=%b exp=0", tutorial_mode); end
        tick(1);
        checks++;
        if ({tutorial_mode, selected_a_mode} !== 2'b11) begin
            failures++; $display("FAIL commit_tutorial got=%b exp=11", {tutorial_mode, selected_a_mode});
        end
        checks++;
        if (cursor !== 2'd2) begin failures++; $display("FAIL commit_cursor got=%0d exp=2", cursor); end
        btn_enter = 1'b0;
        tick(6);
        tutorial_done = 1'b1;
        tick(1);
        tutorial_done = 1'b0;
        checks++;
        if ({end_tutorial, selected_a_mode, end_game_early} !== 3'b110) begin
            failures++; $display("FAIL end_tutorial got=%b exp=110", {end_tutorial, selected_a_mode, end_game_early});
        end
        tick(3);
        checks++;
        if (end_tutorial !== 1'b1) begin failures++; $display("FAIL end_tutorial_hold got=%b exp=1", end_tutorial); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        press(1);
        btn_enter = 1'b1;
        btn_down = 1'b1;
        tick(7);
        checks++;
        if ({cursor, two_player_mode, selected_a_mode} !== 4'b0110) begin
            failures++; $display("FAIL simultaneous got=%b exp=0110", {cursor, two_player_mode, selected_a_mode});
        end
        btn_enter = 1'b0;
        btn_down = 1'b0;
        tick(8);
        press(1);
        checks++;
        if ({cursor, two_player_mode} !== 3'b011) begin
            failures++; $display("FAIL press_outside_menu got=%b exp=011", {cursor, two_player_mode});
        end
    endtask

    task automatic test_quit_hold;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        press(2);
        checks++;
        if (selected_a_mode !== 1'b1) begin failures++; $display("FAIL one_player got=%b exp=1", selected_a_mode); end
        btn_quit = 1'b1;
        tick(9);
        btn_quit = 1'b0;
        tick(8);
        checks++;
        if ({end_game_early, selected_a_mode} !== 2'b01) begin
            failures++; $display("FAIL quit_short got=%b exp=01", {end_game_early, selected_a_mode});
        end
        btn_quit = 1'b1;
        tick(10);
        btn_quit = 1'b0;
        tick(5);
        checks++;
        if (end_game_early !== 1'b0) begin failures++; $display("FAIL quit_before_10 got=%b exp=0", end_game_early); end
        tick(1);
        checks++;
        if (end_game_early !== 1'b1) begin failures++; $display("FAIL quit_at_10 got=%b exp=1", end_game_early); end
        tick(8);
        checks++;
        if ({end_game_early, selected_a_mode, end_tutorial} !== 3'b110) begin
            failures++; $display("FAIL done_hold got=%b exp=110", {end_game_early, selected_a_mode, end_tutorial});
        end
        select_mode_screen = 1'b0;
        play_again = 1'b1;
        tick(1);
        play_again = 1'b0;
        checks++;
        if (obs !== 7'd0) begin failures++; $display("FAIL play_again_clear got=%b exp=%b", obs, 7'd0); end
        tick(2);
        checks++;
        if (obs !== 7'd0) begin failures++; $display("FAIL idle_stays got=%b exp=%b", obs, 7'd0); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        press(1);
        press(2);
        checks++;
        if (two_player_mode !== 1'b1) begin failures++; $display("FAIL two_player got=%b exp=1", two_player_mode); end
        btn_quit = 1'b1;
        tick(11);
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'd0) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, 7'd0); end
        btn_quit = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        press(1);
        press(2);
        btn_quit = 1'b1;
        tick(9);
        btn_quit = 1'b0;
        tick(8);
        checks++;
        if ({two_player_mode, end_game_early} !== 2'b10) begin
            failures++; $display("FAIL quit_after_reset got=%b exp=10", {two_player_mode, end_game_early});
        end
    endtask

    task automatic test_stray_play_again;
        do_reset();
        select_mode_screen = 1'b1;
        tick(2);
        press(0);
        play_again = 1'b1;
        tick(3);
        checks++;
        if (obs !== {2'd2, 5'd0}) begin failures++; $display("FAIL stray_play_again got=%b exp=%b", obs, {2'd2, 5'd0}); end
        play_again = 1'b0;
        press(1);
        checks++;
        if (cursor !== 2'd0) begin failures++; $display("FAIL still_in_menu got=%0d exp=0", cursor); end
    endtask

    // Abstract model: phase 0 idle, 1 menu, 2 one-player, 3 two-player, 4 tutorial, 5 done.
    task automatic test_random;
        int phase, cur, from, egl, etut, op, len;
        logic scr;
        logic [6:0] exp_v, mask;
        do_reset();
        scr = 1'b1;
        select_mode_screen = 1'b1;
        tick(2);
        phase = 1; cur = 0; from = 0; egl = 0; etut = 0;
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    press(0);
                    if (phase == 1) cur = (cur + 2) % 3;
                end
                2: begin
                    press(1);
                    if (phase == 1) cur = (cur + 1) % 3;
                end
                3, 4: begin
                    press(2);
                    if (phase == 1) phase = 2 + cur;
                end
                5: begin
                    scr = ~scr;
                    select_mode_screen = scr;
                    tick(2);
                    if (phase == 1 && !scr) phase = 0;
                end
                6: begin
                    len = $urandom_range(4, 14);
                    btn_quit = 1'b1;
                    tick(len);
                    btn_quit = 1'b0;
                    tick(8);
                    if ((phase == 2 || phase == 3) && len >= 10) begin
                        from = phase; phase = 5; egl = 1;
                    end
                end
                7: begin
                    tutorial_done = 1'b1;
                    tick(1);
                    tutorial_done = 1'b0;
                    tick(2);
                    if (phase == 4) begin from = 4; phase = 5; etut = 1; end
                end
                default: begin
                    play_again = 1'b1;
                    tick(1);
                    play_again = 1'b0;
                    tick(2);
                    if (phase == 5) begin phase = 0; egl = 0; etut = 0; cur = 0; end
                end
            endcase
            if (phase == 0 && scr) begin phase = 1; cur = 0; end
            exp_v[6:5] = 2'(cur);
            exp_v[4] = (phase == 2 || phase == 4 || (phase == 5 && (from == 2 || from == 4)));
            exp_v[3] = (phase == 3 || (phase == 5 && from == 3));
            exp_v[2] = (phase == 4);
            exp_v[1] = (egl != 0);
            exp_v[0] = (etut != 0);
            mask = (phase == 0) ? 7'b0011111 : 7'b1111111;
            checks++;
            if ((obs & mask) !== (exp_v & mask)) begin
                failures++;
                $display("FAIL random_op step=%0d op=%0d got=%b exp=%b", k, op, obs & mask, exp_v & mask);
            end
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        test_reset();
        test_bounce();
        test_wrap_commit();
        test_simultaneous();
        test_quit_hold();
        test_reset_mid();
        test_stray_play_again();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode_select_fsm.md
MODE_SELECT_FSM -- requirements
Module: mode_select_fsm

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 1000000, which is the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 The block SHALL have the parameter QUIT_HOLD_CYCLES, default 100000000, which is the number of consecutive debounced-high cycles of btn_quit needed to end a game early.
REQ-003 clock  in  1  single clock, rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 select_mode_screen  in  1  level, high while the mode menu is displayed.
REQ-006 btn_up, btn_down, btn_enter, btn_quit  in  1 each  raw active-high buttons, asynchronous to clock.
REQ-007 tutorial_done  in  1  level from the tutorial logic.
REQ-008 play_again  in  1  level from the screen timer.
REQ-009 cursor  out  2  menu highlight: 0 = one-player, 1 = two-player, 2 = tutorial.
REQ-010 selected_a_mode  out  1  high while the one-player or tutorial mode is committed.
REQ-011 two_player_mode  out  1  high while the two-player mode is committed.
REQ-012 tutorial_mode  out  1  high while the tutorial is committed.
REQ-013 end_game_early  out  1  level, high in DONE when entered by quit.
REQ-014 end_tutorial  out  1  level, high in DONE when entered from TUTORIAL.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Each synchronized button SHALL have an independent debounce counter, sized to hold DEBOUNCE_CYCLES.
REQ-017 The debounced level SHALL change only after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level; any agreeing sample SHALL clear the counter.
REQ-018 A press SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; a held button SHALL produce exactly one press.
REQ-019 The FSM SHALL have the states IDLE, MENU, ONE_PLAYER, TWO_PLAYER, TUTORIAL and DONE.
REQ-020 IDLE -> MENU SHALL occur on the first cycle that select_mode_screen = 1; cursor SHALL be set to 0 on entry.
REQ-021 In MENU, an up press SHALL decrement cursor with wrap 0->2, and a down press SHALL increment cursor with wrap 2->0; cursor SHALL never take the value 3.
REQ-022 In MENU, an enter press SHALL commit the current cursor: 0 -> ONE_PLAYER, 1 -> TWO_PLAYER, 2 -> TUTORIAL, effective next cycle.
REQ-023 For presses in the same cycle in MENU, the priority SHALL be enter > up > down; when enter wins, the cursor SHALL NOT move that cycle.
REQ-024 In MENU, if select_mode_screen falls before commit, the FSM SHALL return to IDLE with no mode output set.
REQ-025 The outputs SHALL be Moore-decoded from the state: selected_a_mode = ONE_PLAYER or TUTORIAL or (DONE from either of those); two_player_mode = TWO_PLAYER or (DONE from TWO_PLAYER); tutorial_mode = TUTORIAL.
REQ-026 In ONE_PLAYER and TWO_PLAYER, a quit counter SHALL increment while btn_quit is debounced-high and clear when it is low.
REQ-027 When the quit counter reaches QUIT_HOLD_CYCLES the FSM SHALL move to DONE with end_game_early = 1; the quit counter SHALL saturate and never wrap.
REQ-028 In TUTORIAL, tutorial_done = 1 SHALL move the FSM to DONE with end_tutorial = 1; btn_quit SHALL be ignored in TUTORIAL.
REQ-029 In DONE, end_game_early and end_tutorial SHALL hold their values and the mode outputs SHALL hold.
REQ-030 play_again = 1 in DONE SHALL move the FSM to IDLE next cycle, clearing all mode, end and counter outputs.
REQ-031 play_again = 1 in any state other than DONE SHALL be ignored.
REQ-032 Button presses outside MENU SHALL have no effect other than the quit counting in REQ-026.

Reset
REQ-033 Asserting reset_n = 0 SHALL, asynchronously and at any state (including mid-debounce or mid-quit-hold), force the state to IDLE.
REQ-034 Reset SHALL force cursor = 0 and all 1-bit outputs = 0.
REQ-035 Reset SHALL clear all synchronizer flops, debounce counters, debounced levels and the quit counter.
REQ-036 After reset_n rises, the first state change SHALL occur no earlier than the next rising clock edge.

Verification (DEBOUNCE_CYCLES = 4, QUIT_HOLD_CYCLES = 10)
REQ-037 Bench SHALL check button bounce: select_mode_screen = 1, btn_down toggled every 2 cycles for 20 cycles, then held high for 10 cycles -> cursor stays 0 during bouncing and then steps to 1 exactly once.
REQ-038 Bench SHALL check menu wrap and commit: in MENU press up once -> cursor = 2; press enter -> tutorial_mode = 1 and selected_a_mode = 1 next cycle; tutorial_done = 1 -> end_tutorial = 1.
REQ-039 Bench SHALL check simultaneous presses: enter and down debounced high in the same cycle with cursor = 1 -> TWO_PLAYER, cursor stays 1, two_player_mode = 1.
REQ-040 Bench SHALL check quit hold: in ONE_PLAYER hold btn_quit for 9 debounced cycles then release, then hold for 10 cycles -> end_game_early stays 0 after the first hold and rises after the 10th cycle of the second hold; play_again = 1 -> all outputs 0 in IDLE.
REQ-041 Bench SHALL check reset mid-operation: reset_n pulsed low in TWO_PLAYER with the quit counter at 5 -> outputs are 0 immediately; after release, btn_quit held for 9 cycles produces no end_game_early.
REQ-042 Bench SHALL check stray play_again: play_again = 1 in MENU -> state and cursor unchanged.
